// File: rtl/pipe_hazard_if.sv
// Hazard-unit bundle: ID-stage instruction fields and branch resolve in,
// stall/flush/forwarding controls out.
interface pipe_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_wr;
  logic                  id_is_load;
  logic                  ex_branch_taken;
  logic                  fe_hold;
  logic                  id_bubble;
  logic                  flush_ifid;
  logic [SEL_W-1:0]      fwd_rs1_sel;
  logic [SEL_W-1:0]      fwd_rs2_sel;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wr, id_is_load, ex_branch_taken,
    input  fe_hold, id_bubble, flush_ifid, fwd_rs1_sel, fwd_rs2_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wr, id_is_load, ex_branch_taken,
    output fe_hold, id_bubble, flush_ifid, fwd_rs1_sel, fwd_rs2_sel, stall_count
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: destination scoreboard for EX..WB, load-use stall,
// forwarding select and taken-branch IF/ID flush with a stall counter.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave hz
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  logic [DEPTH-1:0]      sb_valid;
  logic [DEPTH-1:0]      sb_load;
  logic [REG_ADDR_W-1:0] sb_rd [DEPTH];
  logic [FC_W-1:0]       flush_cnt;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  hazard;
  logic                  flush;
  logic                  hold;
  logic                  insert;
  logic [SEL_W-1:0]      sel1;
  logic [SEL_W-1:0]      sel2;

  // Branch wins over a coincident load-use: the bubble still goes in, but fetch is not held.
  always_comb begin
    hazard = sb_valid[0] & sb_load[0] & hz.id_valid &
             ((hz.id_rs1_used & (hz.id_rs1 == sb_rd[0])) |
              (hz.id_rs2_used & (hz.id_rs2 == sb_rd[0])));
    flush  = rst & (hz.ex_branch_taken | (flush_cnt != '0));
    hold   = hazard & ~flush;
    insert = hz.id_valid & hz.id_rd_wr & (hz.id_rd != '0) & ~hazard & ~flush;
  end

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_valid[k] && !(k == 0 && sb_load[0])) begin
        if (hz.id_rs1_used && (hz.id_rs1 == sb_rd[k])) sel1 = SEL_W'(k + 1);
        if (hz.id_rs2_used && (hz.id_rs2 == sb_rd[k])) sel2 = SEL_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      sb_load  <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      sb_valid <= {sb_valid[DEPTH-2:0], insert};
      sb_load  <= {sb_load[DEPTH-2:0], hz.id_is_load};
      sb_rd[0] <= hz.id_rd;
      for (int i = 1; i < DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (hz.ex_branch_taken) begin
      flush_cnt <= FC_W'(FLUSH_CYCLES);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.fe_hold     = hold;
  assign hz.id_bubble   = hazard;
  assign hz.flush_ifid  = flush;
  assign hz.fwd_rs1_sel = sel1;
  assign hz.fwd_rs2_sel = sel2;
  assign hz.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios then random traffic, both
// against a queue-based model of in-flight instructions; a CNT_W=2 twin checks saturation.
module tb_pipe_hazard_unit;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int FC    = 2;
  localparam int SW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_if #(.REG_ADDR_W(AW), .SEL_W(SW), .CNT_W(16)) ifm ();
  pipe_hazard_if #(.REG_ADDR_W(AW), .SEL_W(SW), .CNT_W(2))  ifs ();

  assign ifs.id_valid        = ifm.id_valid;
  assign ifs.id_rs1          = ifm.id_rs1;
  assign ifs.id_rs2          = ifm.id_rs2;
  assign ifs.id_rs1_used     = ifm.id_rs1_used;
  assign ifs.id_rs2_used     = ifm.id_rs2_used;
  assign ifs.id_rd           = ifm.id_rd;
  assign ifs.id_rd_wr        = ifm.id_rd_wr;
  assign ifs.id_is_load      = ifm.id_is_load;
  assign ifs.ex_branch_taken = ifm.ex_branch_taken;

  pipe_hazard_unit #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(16), .SEL_W(SW))
    dut (.clk(clk), .rst(rst), .hz(ifm));
  pipe_hazard_unit #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(2), .SEL_W(SW))
    dut_s (.clk(clk), .rst(rst), .hz(ifs));

  typedef struct {bit v; int rd; bit ld;} ent_t;
  ent_t inflight[$];   // index 0 = youngest (EX)
  int   br_age;        // edges since the last taken-branch pulse
  int   stalls;
  int   total = 0;
  int   bad   = 0;
  bit   e_hold, e_bub, e_flush;
  int   e_f1, e_f2;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ent_t e = '{v: 1'b0, rd: 0, ld: 1'b0};
    inflight.delete();
    for (int i = 0; i < DEPTH; i++) inflight.push_back(e);
    br_age = 1000;
    stalls = 0;
  endfunction

  function automatic int fwd_of(int rs, bit used);
    if (!used) return 0;
    foreach (inflight[k])
      if (inflight[k].v && inflight[k].rd == rs && !(k == 0 && inflight[k].ld)) return k + 1;
    return 0;
  endfunction

  function automatic void model_eval();
    ent_t y = inflight[0];
    int rs1 = int'(ifm.id_rs1);
    int rs2 = int'(ifm.id_rs2);
    e_flush = ifm.ex_branch_taken || (br_age <= FC);
    e_bub   = ifm.id_valid && y.v && y.ld &&
              ((ifm.id_rs1_used && rs1 == y.rd) || (ifm.id_rs2_used && rs2 == y.rd));
    e_hold  = e_bub && !e_flush;
    e_f1    = fwd_of(rs1, ifm.id_rs1_used);
    e_f2    = fwd_of(rs2, ifm.id_rs2_used);
  endfunction

  function automatic void model_clock();
    ent_t n;
    if (e_hold) stalls++;
    n.v  = !(e_bub || e_flush) && ifm.id_valid && ifm.id_rd_wr && (ifm.id_rd != 0);
    n.rd = int'(ifm.id_rd);
    n.ld = ifm.id_is_load;
    inflight.push_front(n);
    void'(inflight.pop_back());
    if (ifm.ex_branch_taken) br_age = 1;
    else if (br_age < 1000)  br_age++;
  endfunction

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld, bit br);
    ifm.id_valid        = v;
    ifm.id_rs1          = rs1[AW-1:0];
    ifm.id_rs1_used     = u1;
    ifm.id_rs2          = rs2[AW-1:0];
    ifm.id_rs2_used     = u2;
    ifm.id_rd           = rd[AW-1:0];
    ifm.id_rd_wr        = wr;
    ifm.id_is_load      = ld;
    ifm.ex_branch_taken = br;
  endtask

  task automatic settle_check(string tag);
    #1;
    model_eval();
    chk({tag, ".fe_hold"},    ifm.fe_hold,     e_hold);
    chk({tag, ".id_bubble"},  ifm.id_bubble,   e_bub);
    chk({tag, ".flush_ifid"}, ifm.flush_ifid,  e_flush);
    chk({tag, ".fwd_rs1"},    ifm.fwd_rs1_sel, e_f1);
    chk({tag, ".fwd_rs2"},    ifm.fwd_rs2_sel, e_f2);
    chk({tag, ".stall_cnt"},  ifm.stall_count, stalls);
    chk({tag, ".stall_sat"},  ifs.stall_count, (stalls > 3) ? 3 : stalls);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".fe_hold"},    ifm.fe_hold,     0);
    chk({tag, ".id_bubble"},  ifm.id_bubble,   0);
    chk({tag, ".flush_ifid"}, ifm.flush_ifid,  0);
    chk({tag, ".fwd_rs1"},    ifm.fwd_rs1_sel, 0);
    chk({tag, ".fwd_rs2"},    ifm.fwd_rs2_sel, 0);
    chk({tag, ".stall_cnt"},  ifm.stall_count, 0);
    chk({tag, ".stall_sat"},  ifs.stall_count, 0);
  endtask

  initial begin
    int saved;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle_check("idle"); tick();

    // load x5 then add x6,x5,x1
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0); settle_check("s033_ld"); tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0); settle_check("s033_use");
    chk("s033_hold", ifm.fe_hold, 1);
    chk("s033_bubble", ifm.id_bubble, 1);
    tick();
    settle_check("s033_after");
    chk("s033_fwd", ifm.fwd_rs1_sel, 2);
    chk("s033_cnt", ifm.stall_count, 1);
    tick();

    // three writers of x3, then a reader
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0); settle_check("s034_wr"); tick();
    end
    drive(1, 3, 1, 3, 1, 8, 1, 0, 0); settle_check("s034_rd");
    chk("s034_fwd1", ifm.fwd_rs1_sel, 1);
    chk("s034_fwd2", ifm.fwd_rs2_sel, 1);
    tick();

    // x0 never forwarded
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); settle_check("s035_wr"); tick();
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0); settle_check("s035_rd");
    chk("s035_fwd1", ifm.fwd_rs1_sel, 0);
    chk("s035_hold", ifm.fe_hold, 0);
    tick();

    // taken branch: three flush cycles, writers during them never enter the scoreboard
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1); settle_check("s036_pulse");
    chk("s036_f0", ifm.flush_ifid, 1);
    tick();
    for (int i = 0; i < FC; i++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0); settle_check("s036_hold");
      chk("s036_fn", ifm.flush_ifid, 1);
      tick();
    end
    drive(1, 7, 1, 0, 0, 9, 0, 0, 0); settle_check("s036_end");
    chk("s036_off", ifm.flush_ifid, 0);
    chk("s036_fwd", ifm.fwd_rs1_sel, 0);
    tick();

    // load-use coincident with a taken branch
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); settle_check("s037_ld"); tick();
    saved = int'(ifm.stall_count);
    drive(1, 9, 1, 0, 0, 10, 1, 0, 1); settle_check("s037_use");
    chk("s037_hold", ifm.fe_hold, 0);
    chk("s037_bubble", ifm.id_bubble, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle_check("s037_after");
    chk("s037_cnt", ifm.stall_count, saved);
    tick(); tick(); tick();

    // five load-use stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 11 + i, 1, 1, 0); settle_check("s038_ld"); tick();
      drive(1, 0, 1, 11 + i, 1, 20, 1, 0, 0); settle_check("s038_use"); tick();
    end
    settle_check("s038_sat");
    chk("s038_sat3", ifs.stall_count, 3);

    // reset in the middle of a flush
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); settle_check("s038_br"); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("s038_rst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); settle_check("cold"); tick();

    // random traffic over a small register set
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      settle_check("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
